dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequential arbiter that shares the single data memory port between two requesters: the core load/store path (port C) and a secondary master such as a debug loader or DMA engine (port D). Each access runs a fixed three-state FSM: arbitrate, issue, respond. A one-cycle ack handshake closes each access. Between the core's ALU address/store-data outputs and `data_mem`, the block produces `core_stall` so the PC holds while the core's access is outstanding.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MW`, 3, access-mode width (same encoding as `mem_acc_mode`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous and active-high
- `c_req`, `d_req`  in  1  access request. Held high, with all request fields stable, until the matching ack.
- `c_we`, `d_we`  in  1  1 = store, 0 = load
- `c_addr`, `d_addr`  in  AW  byte address
- `c_wdata`, `d_wdata`  in  DW  store data
- `c_mode`, `d_mode`  in  MW  access size and sign mode
- `c_ack`, `d_ack`  out  1  one-cycle completion pulse
- `c_rdata`, `d_rdata`  out  DW  load data
- `core_stall`  out  1  equals `c_req & ~c_ack`
- `m_en`, `m_we`  out  1  memory enable and write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_mode`  out  MW  memory access mode
- `m_rdata`  in  DW  memory read data; synchronous read, valid in the cycle after `m_en`

## Operation
- **State machine: IDLE → ACCESS → DONE → IDLE.** Every access takes this path, loads and stores alike.
- **IDLE.**
  - If any request is high, latch `owner` and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS.**
  - `m_en` = 1.
  - `m_we`, `m_addr`, `m_wdata` and `m_mode` are muxed from the owner's live inputs.
  - Always go to DONE.
- **DONE.**
  - Pulse the owner's ack.
  - The owner's rdata is driven combinationally from `m_rdata`.
  - At the end of the cycle, `m_rdata` is loaded into that port's hold register (loads only).
  - Go to IDLE.
- **rdata outside DONE.** Each port's rdata shows its hold register and holds until that port's next load completes. The other port's rdata never changes.
- **Tie-break (both requests high in IDLE).**
  - The winner is the port not recorded in `last_owner`; see Configuration.
  - `last_owner` updates when leaving IDLE.
- **Back-to-back requests.** A request still high in the cycle after its ack counts as a new request.
- **Memory outputs outside ACCESS.** `m_en` = 0 and `m_we` = 0; the address and data outputs are don't-care.
- **Request dropped early (protocol violation).** The access still completes and the ack is still pulsed.

## Timing
- **Reset values:**
  - state = IDLE
  - `c_ack`, `d_ack`, `m_en`, `m_we` = 0
  - `c_rdata` and `d_rdata` hold registers = 0
  - `last_owner` = D, so the core wins the first tie
- **Latency, request to ack:**
  - A request seen in cycle N while the FSM is in IDLE is acked in cycle N+2.
  - A request arriving while the other port is being served waits until the next IDLE.
- **Throughput:** one access per 3 cycles.
- **Worst-case core wait:** with round-robin, one D access plus its own access, i.e. 5 cycles.
- **Reset asserted in ACCESS or DONE:**
  - The FSM is in IDLE and `m_en` = 0 from the next cycle.
  - No ack is issued after the reset cycle.
  - A store whose ACCESS cycle has already been clocked is considered performed.
- **`core_stall`:** combinational, zero latency. It is 0 in the cycle `c_ack` = 1, which lets the PC advance on that edge.

## Configuration
- Macro: `DMEM_ARB_RR_EN`.
- **Defined:** round-robin tie-break using `last_owner`, as described above.
- **Undefined:**
  - Fixed priority: C always beats D in IDLE, and `last_owner` is not implemented.
  - D can starve while the core issues continuous requests. This is acceptable for loader-only use while the core is held.

## Structure
- **Package `dmem_arb_pkg`:**
  - `arb_state_e` (IDLE, ACCESS, DONE)
  - `arb_owner_e` (OWN_C, OWN_D)
  - the default width constants `AW`, `DW`, `MW`
- **Sub-module `arb_pick`:** combinational winner selection from (`c_req`, `d_req`, `last_owner`). The macro switches between its round-robin and fixed-priority bodies. All state stays in `dmem_arbiter`.

## Test plan
- **Reset:** assert `rst` for 2 cycles. Then `m_en` = 0, both acks = 0, both rdata = 0, `core_stall` = 0.
- **Core load:**
  - Stimulus: C reads `0x100`, memory returns `0xDEADBEEF`.
  - `m_en` = 1 in cycle N+1 with `m_addr` = `0x100`.
  - `c_ack` = 1 in cycle N+2 with `c_rdata` = `0xDEADBEEF`, holding afterwards.
  - `core_stall` = 1 in cycles N and N+1.
- **D store:**
  - Stimulus: D writes `0x00000055` to `0x20` with mode byte.
  - `m_we` = 1, `m_wdata` = `0x55`, `m_mode` = byte in ACCESS.
  - `d_ack` pulses exactly once; `c_rdata` is unchanged.
- **Simultaneous requests (RR enabled):**
  - Stimulus: both ports request continuously for 4 accesses.
  - Grant order is C, D, C, D; acks fall on cycles 2, 5, 8, 11.
- **Simultaneous requests (RR disabled):** same stimulus gives grant order C, C, C, C, and `d_ack` never rises.
- **Reset mid-access:**
  - Stimulus: assert `rst` during ACCESS of a C load.
  - No `c_ack` is issued; FSM is in IDLE next cycle.
  - After release, a re-request completes normally in 2 cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
// Purpose : FSM state and owner encodings plus default bus widths.
// Ports   : none (package).
// Config  : DMEM_ARB_RR_EN selects round-robin tie-break in arb_pick / dmem_arbiter.
package dmem_arb_pkg;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_C = 1'b0,
      OWN_D = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request, response and memory-side bundle of the arbiter
// Purpose : groups port C, port D and the memory port into one interface.
// Ports   : c_*/d_* requester fields, c_ack/d_ack, c_rdata/d_rdata, core_stall,
//           m_en/m_we/m_addr/m_wdata/m_mode towards memory, m_rdata back.
// Modports: slave  - the arbiter side
//           master - requesters plus memory model side
// Config  : DMEM_ARB_RR_EN does not affect this file.
interface dmem_arbiter_if #(
   parameter int AW = dmem_arb_pkg::AW,
   parameter int DW = dmem_arb_pkg::DW,
   parameter int MW = dmem_arb_pkg::MW
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic [MW-1:0] c_mode;
   logic          c_ack;
   logic [DW-1:0] c_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [MW-1:0] d_mode;
   logic          d_ack;
   logic [DW-1:0] d_rdata;

   logic          core_stall;

   logic          m_en;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [MW-1:0] m_mode;
   logic [DW-1:0] m_rdata;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata, c_mode,
      input  d_req, d_we, d_addr, d_wdata, d_mode,
      input  m_rdata,
      output c_ack, c_rdata, d_ack, d_rdata, core_stall,
      output m_en, m_we, m_addr, m_wdata, m_mode
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata, c_mode,
      output d_req, d_we, d_addr, d_wdata, d_mode,
      output m_rdata,
      input  c_ack, c_rdata, d_ack, d_rdata, core_stall,
      input  m_en, m_we, m_addr, m_wdata, m_mode
   );

endinterface

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection for the data-memory arbiter
// Purpose : picks which requester owns the next access; holds no state.
// Ports   : c_req, d_req - live requests
//           last_owner   - previous owner (only when DMEM_ARB_RR_EN is defined)
//           any_req      - at least one request is pending
//           winner       - selected owner, meaningful only when any_req = 1
// Config  : DMEM_ARB_RR_EN defined   -> round-robin on ties
//           DMEM_ARB_RR_EN undefined -> fixed priority, C beats D
module arb_pick
   import dmem_arb_pkg::*;
(
   input  logic       c_req,
   input  logic       d_req,
`ifdef DMEM_ARB_RR_EN
   input  arb_owner_e last_owner,
`endif
   output logic       any_req,
   output arb_owner_e winner
);

   always_comb begin
      any_req = c_req | d_req;
`ifdef DMEM_ARB_RR_EN
      // On a tie the port that did not own the previous access wins.
      if (c_req && (!d_req || (last_owner == OWN_D))) begin
         winner = OWN_C;
      end else begin
         winner = OWN_D;
      end
`else
      winner = c_req ? OWN_C : OWN_D;
`endif
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data-memory port between the core (C) and a secondary master (D)
// Purpose : IDLE -> ACCESS -> DONE access sequence, one-cycle ack, per-port
//           read-data hold registers and the core stall signal.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset
//           bus  - dmem_arbiter_if.slave (requests, acks, rdata, memory port)
// Config  : DMEM_ARB_RR_EN defined enables round-robin tie-break with last_owner;
//           undefined gives fixed priority to C.
module dmem_arbiter #(
   parameter int AW = dmem_arb_pkg::AW,
   parameter int DW = dmem_arb_pkg::DW,
   parameter int MW = dmem_arb_pkg::MW
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);
   import dmem_arb_pkg::*;

   arb_state_e    state_q, state_d;
   arb_owner_e    owner_q, owner_d;
   logic          we_q, we_d;
   logic          m_en_q, m_en_d;
   logic          c_ack_q, c_ack_d;
   logic          d_ack_q, d_ack_d;
   logic [DW-1:0] c_hold_q, c_hold_d;
   logic [DW-1:0] d_hold_q, d_hold_d;
`ifdef DMEM_ARB_RR_EN
   arb_owner_e    last_owner_q, last_owner_d;
`endif

   logic          pick_any;
   arb_owner_e    pick_owner;
   logic [AW-1:0] addr_sel;
   logic [DW-1:0] wdata_sel;
   logic [MW-1:0] mode_sel;
   logic          we_sel;

   arb_pick u_pick (
      .c_req      (bus.c_req),
      .d_req      (bus.d_req),
`ifdef DMEM_ARB_RR_EN
      .last_owner (last_owner_q),
`endif
      .any_req    (pick_any),
      .winner     (pick_owner)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      m_en_d   = 1'b0;
      c_ack_d  = 1'b0;
      d_ack_d  = 1'b0;
      c_hold_d = c_hold_q;
      d_hold_d = d_hold_q;
`ifdef DMEM_ARB_RR_EN
      last_owner_d = last_owner_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = ACCESS;
               owner_d = pick_owner;
               // Direction is latched so the hold-register update survives an
               // early request drop.
               we_d    = (pick_owner == OWN_C) ? bus.c_we : bus.d_we;
               m_en_d  = 1'b1;
`ifdef DMEM_ARB_RR_EN
               last_owner_d = pick_owner;
`endif
            end
         end
         ACCESS: begin
            state_d = DONE;
            if (owner_q == OWN_C) begin
               c_ack_d = 1'b1;
            end else begin
               d_ack_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!we_q) begin
               if (owner_q == OWN_C) begin
                  c_hold_d = bus.m_rdata;
               end else begin
                  d_hold_d = bus.m_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= OWN_C;
         we_q     <= 1'b0;
         m_en_q   <= 1'b0;
         c_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         c_hold_q <= '0;
         d_hold_q <= '0;
`ifdef DMEM_ARB_RR_EN
         // D recorded as last owner so the core wins the first tie.
         last_owner_q <= OWN_D;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         m_en_q   <= m_en_d;
         c_ack_q  <= c_ack_d;
         d_ack_q  <= d_ack_d;
         c_hold_q <= c_hold_d;
         d_hold_q <= d_hold_d;
`ifdef DMEM_ARB_RR_EN
         last_owner_q <= last_owner_d;
`endif
      end
   end

   // Memory fields follow the owner's live inputs; only meaningful in ACCESS.
   always_comb begin
      if (owner_q == OWN_C) begin
         addr_sel  = bus.c_addr;
         wdata_sel = bus.c_wdata;
         mode_sel  = bus.c_mode;
         we_sel    = bus.c_we;
      end else begin
         addr_sel  = bus.d_addr;
         wdata_sel = bus.d_wdata;
         mode_sel  = bus.d_mode;
         we_sel    = bus.d_we;
      end
   end

   assign bus.m_en    = m_en_q;
   assign bus.m_we    = m_en_q & we_sel;
   assign bus.m_addr  = addr_sel;
   assign bus.m_wdata = wdata_sel;
   assign bus.m_mode  = mode_sel;

   assign bus.c_ack   = c_ack_q;
   assign bus.d_ack   = d_ack_q;

   // In DONE the owner sees the synchronous read data directly.
   assign bus.c_rdata = ((state_q == DONE) && (owner_q == OWN_C)) ? bus.m_rdata : c_hold_q;
   assign bus.d_rdata = ((state_q == DONE) && (owner_q == OWN_D)) ? bus.m_rdata : d_hold_q;

   assign bus.core_stall = bus.c_req & ~c_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
// Purpose : reset, core load, D store, simultaneous requests, reset mid-access.
// Ports   : none (top-level bench); memory is a word array with synchronous read.
// Config  : expectations follow DMEM_ARB_RR_EN (round-robin) or its absence.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   dmem_arbiter_if bus ();

   dmem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];

   always @(posedge clk) begin
      if (rst) begin
         bus.m_rdata <= 32'h0;
      end else if (bus.m_en) begin
         if (bus.m_we) begin
            mem[bus.m_addr[9:2]] <= bus.m_wdata;
         end else begin
            bus.m_rdata <= mem[bus.m_addr[9:2]];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_c;
   logic [3:0] exp_d;
   int         acks;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[64] = 32'hDEADBEEF;
      mem[65] = 32'h12345678;
      bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_mode = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_mode = 0;

      // Reset
      rst = 1;
      tick();
      tick();
      rst = 0;
      #1;
      chk("rst_m_en", bus.m_en, 0);
      chk("rst_c_ack", bus.c_ack, 0);
      chk("rst_d_ack", bus.d_ack, 0);
      chk("rst_c_rdata", bus.c_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      chk("rst_stall", bus.core_stall, 0);

      // Core load from 0x100
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h100; bus.c_mode = 3'b010;
      #1;
      chk("ld_stall_n0", bus.core_stall, 1);
      tick();
      chk("ld_m_en", bus.m_en, 1);
      chk("ld_m_addr", bus.m_addr, 32'h100);
      chk("ld_m_we", bus.m_we, 0);
      chk("ld_ack_n1", bus.c_ack, 0);
      chk("ld_stall_n1", bus.core_stall, 1);
      tick();
      chk("ld_ack_n2", bus.c_ack, 1);
      chk("ld_rdata_n2", bus.c_rdata, 32'hDEADBEEF);
      chk("ld_stall_n2", bus.core_stall, 0);
      bus.c_req = 0;
      tick();
      chk("ld_ack_n3", bus.c_ack, 0);
      chk("ld_rdata_hold", bus.c_rdata, 32'hDEADBEEF);
      chk("ld_m_en_n3", bus.m_en, 0);

      // D store of 0x55 to 0x20, byte mode
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h55; bus.d_mode = 3'b000;
      #1;
      chk("st_stall", bus.core_stall, 0);
      tick();
      chk("st_m_en", bus.m_en, 1);
      chk("st_m_we", bus.m_we, 1);
      chk("st_m_wdata", bus.m_wdata, 32'h55);
      chk("st_m_mode", bus.m_mode, 3'b000);
      chk("st_m_addr", bus.m_addr, 32'h20);
      tick();
      acks = bus.d_ack;
      chk("st_ack", bus.d_ack, 1);
      bus.d_req = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         acks += bus.d_ack;
      end
      chk("st_ack_count", acks, 1);
      chk("st_c_rdata", bus.c_rdata, 32'hDEADBEEF);
      chk("st_m_we_idle", bus.m_we, 0);
      chk("st_mem", mem[8], 32'h55);

      // Simultaneous continuous requests for four accesses
`ifdef DMEM_ARB_RR_EN
      exp_c = 4'b0101;
      exp_d = 4'b1010;
`else
      exp_c = 4'b1111;
      exp_d = 4'b0000;
`endif
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h100; bus.c_mode = 3'b010;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h104; bus.d_mode = 3'b010;
      acks = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc > 0) tick();
         acks += bus.c_ack + bus.d_ack;
         if (cyc % 3 == 2) begin
            chk($sformatf("tie_c_ack_%0d", cyc), bus.c_ack, exp_c[cyc / 3]);
            chk($sformatf("tie_d_ack_%0d", cyc), bus.d_ack, exp_d[cyc / 3]);
         end
      end
      chk("tie_ack_total", acks, 4);
      bus.c_req = 0;
      bus.d_req = 0;
      tick();
`ifdef DMEM_ARB_RR_EN
      chk("tie_d_rdata", bus.d_rdata, 32'h12345678);
`else
      chk("tie_d_rdata", bus.d_rdata, 32'h0);
`endif
      chk("tie_c_rdata", bus.c_rdata, 32'hDEADBEEF);

      // Reset during ACCESS of a core load
      tick();
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h100;
      tick();
      chk("rma_m_en", bus.m_en, 1);
      rst = 1;
      tick();
      chk("rma_c_ack", bus.c_ack, 0);
      chk("rma_m_en_off", bus.m_en, 0);
      chk("rma_c_rdata", bus.c_rdata, 0);
      rst = 0;
      tick();
      chk("rma_re_m_en", bus.m_en, 1);
      chk("rma_re_ack_n1", bus.c_ack, 0);
      tick();
      chk("rma_re_ack_n2", bus.c_ack, 1);
      chk("rma_re_rdata", bus.c_rdata, 32'hDEADBEEF);
      bus.c_req = 0;
      tick();
      chk("rma_ack_off", bus.c_ack, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
